id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised decode stage with built-in ID/EXE pipeline register and valid/ready handshake.
//  Decodes ARM-subset instructions, reads a NREG x DATA_W register file and evaluates the condition
//  field against SR. Inserts bubbles on hazard, condition-fail or flush.
//  Sits between the IF/ID register and EXE; src1/src2/two_src/has_rn feed the hazard unit combinationally.
// PARAMETERS
//  DATA_W  32  register/data width
//  NREG    16  architectural registers; index width RW = $clog2(NREG), must be <= 4 (4-bit fields)
// PORTS
//  clk          in   1       clock, all state on posedge
//  rst          in   1       synchronous, active-low reset
//  in_valid     in   1       instr/pc valid from IF/ID
//  in_ready     out  1       stage accepts instr this cycle
//  instr        in   32      instruction word
//  pc           in   DATA_W  pc of instr, forwarded
//  sr           in   4       status flags {N,Z,C,V}
//  hazard       in   1       hazard unit stall request
//  flush        in   1       branch taken in EXE: squash
//  wb_en        in   1       register write enable
//  wb_dest      in   RW      write index
//  wb_data      in   DATA_W  write data
//  src1,src2    out  RW      Rn; Rm, or Rd when store (comb.)
//  two_src      out  1       ~I | store (comb.)
//  has_rn       out  1       instr reads Rn (comb.: 0 for MOV/MVN/B)
//  out_valid    out  1       EXE register holds an instruction
//  out_ready    in   1       EXE consumes this cycle
//  out_exe_cmd  out  4       ALU command
//  out_mem_r, out_mem_w, out_wb_en, out_b, out_s  out 1 each  control bits
//  out_val_rn, out_val_rm  out  DATA_W  operand values
//  out_imm      out  1       I bit
//  out_shift_op out  12      instr[11:0]
//  out_simm24   out  24      instr[23:0]
//  out_dest     out  RW      Rd
//  out_pc       out  DATA_W  pc
// BEHAVIOUR
//  - Reset (rst=0 at posedge): every out_* register 0, out_valid=0, all NREG registers 0.
//  - Latency 1: instr accepted at edge N appears on out_* after edge N.
//  - Advance: adv = ~out_valid | out_ready. in_ready = adv & ~hazard & ~flush.
//  - Load at edge when adv: accept = in_valid & in_ready; out_valid <= accept.
//      On accept, datapath fields are loaded; control bits = decoded & cond_pass.
//      cond_pass=0 -> valid slot with all six controls 0 (architectural NOP).
//  - Hold when ~adv: all out_* keep value, hazard ignored.
//  - flush=1 overrides all: out_valid<=0, controls<=0, and no instr accepted that cycle.
//  - Bubble (adv & ~accept): out_valid=0, controls=0; datapath fields don't-care.
//  - Decode table (mode = instr[27:26], opcode = instr[24:21]):
//      mode 00: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011,
//               SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111,
//               EOR 0001->1000 (wb=1, s=instr[20]).
//               CMP 1010->0100 and TST 1000->0110 (wb=0, s=1).
//      mode 01: cmd 0010; instr[20]=1 -> LDR (mem_r, wb); 0 -> STR (mem_w).
//      mode 10: B=1; other controls 0.
//      Other modes/opcodes: all controls 0.
//  - Cond codes: 0000..1101 per ARM; 1110 = always; 1111 = never.
//  - Regfile: 2 comb. read ports, 1 write port at posedge when wb_en.
//      Index >= NREG: write ignored, read returns 0.
//  - Reset during a stall: clears everything; first instr after release is accepted normally.
// CONFIGURATION
//  ID_WB_BYPASS_EN defined:
//    a read of index == wb_dest while wb_en returns wb_data in the same cycle (write-through).
//  ID_WB_BYPASS_EN undefined:
//    the read returns the old stored value; the hazard unit must cover WB-distance dependencies.
// TESTING
//  1. Reset, then ADD R1,R2,R3 (cond 1110), R2=5, R3=7, out_ready=1
//     -> next cycle out_valid=1, exe_cmd=0010, wb=1, val_rn=5, val_rm=7, dest=1.
//  2. hazard=1 for 2 cycles with in_valid=1 -> in_ready=0, two bubbles (out_valid=0);
//     same instr issues on the cycle after hazard drops.
//  3. out_ready=0 with out_valid=1 for 3 cycles -> out_* stable, in_ready=0;
//     flush=1 then -> out_valid=0 next cycle.
//  4. BEQ with SR Z=0 -> out_valid=1, b=0, all controls 0;
//     with Z=1 -> b=1, simm24=instr[23:0].
//  5. STR R4,[R5] -> src2=4, two_src=1, mem_w=1, wb=0;
//     LDR -> mem_r=1, wb=1; CMP -> wb=0, s=1.
//  6. wb_en=1, wb_dest=2, wb_data=0xA5 with ADD reading R2 same cycle:
//     val_rn=0xA5 with ID_WB_BYPASS_EN defined, old value without it.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: upstream (IF/ID) and downstream (EXE) handshake buses of the decode stage.
// master = environment side (fetch + execute), slave = the decode stage itself.
interface id_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int RW     = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [DATA_W-1:0] pc;

  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_exe_cmd;
  logic              out_mem_r;
  logic              out_mem_w;
  logic              out_wb_en;
  logic              out_b;
  logic              out_s;
  logic [DATA_W-1:0] out_val_rn;
  logic [DATA_W-1:0] out_val_rm;
  logic              out_imm;
  logic [11:0]       out_shift_op;
  logic [23:0]       out_simm24;
  logic [RW-1:0]     out_dest;
  logic [DATA_W-1:0] out_pc;

  modport master (
    output in_valid, instr, pc, out_ready,
    input  in_ready, out_valid, out_exe_cmd, out_mem_r, out_mem_w, out_wb_en, out_b, out_s,
           out_val_rn, out_val_rm, out_imm, out_shift_op, out_simm24, out_dest, out_pc
  );

  modport slave (
    input  in_valid, instr, pc, out_ready,
    output in_ready, out_valid, out_exe_cmd, out_mem_r, out_mem_w, out_wb_en, out_b, out_s,
           out_val_rn, out_val_rm, out_imm, out_shift_op, out_simm24, out_dest, out_pc
  );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: ARM-subset decode stage with built-in ID/EXE register and valid/ready handshake.
// Define ID_WB_BYPASS_EN to forward the WB write port onto the register-file read ports.
module id_stage_pipe #(
  parameter  int DATA_W = 32,
  parameter  int NREG   = 16,
  localparam int RW     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  id_stage_pipe_if.slave    bus,
  input  logic [3:0]        sr,
  input  logic              hazard,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [RW-1:0]     wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic [RW-1:0]     src1,
  output logic [RW-1:0]     src2,
  output logic              two_src,
  output logic              has_rn
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  logic [3:0]        cond, opcode, rn_f, rd_f, rm_f;
  logic [1:0]        mode;
  logic              imm_bit, s_bit, is_store;
  logic              n_f, z_f, c_f, v_f;
  logic              cond_pass;
  logic [3:0]        dec_cmd;
  logic              dec_mem_r, dec_mem_w, dec_wb, dec_b, dec_s;
  logic [8:0]        dec_ctrl;
  logic              adv, accept;
  logic [DATA_W-1:0] rd_rn, rd_rm;

  logic [DATA_W-1:0] regs [NREG];

  logic              out_valid_q;
  logic [8:0]        ctrl_q;
  logic [DATA_W-1:0] val_rn_q, val_rm_q, pc_q;
  logic              imm_q;
  logic [11:0]       shift_q;
  logic [23:0]       simm_q;
  logic [RW-1:0]     dest_q;

  function automatic logic in_range(input logic [RW-1:0] idx);
    return 32'(idx) < 32'(NREG);
  endfunction

  assign cond     = bus.instr[31:28];
  assign mode     = bus.instr[27:26];
  assign imm_bit  = bus.instr[25];
  assign opcode   = bus.instr[24:21];
  assign s_bit    = bus.instr[20];
  assign rn_f     = bus.instr[19:16];
  assign rd_f     = bus.instr[15:12];
  assign rm_f     = bus.instr[3:0];
  assign {n_f, z_f, c_f, v_f} = sr;

  // Stores read Rd as their second source so the data to write reaches EXE.
  assign is_store = (mode == 2'b01) && !s_bit;
  assign src1     = rn_f[RW-1:0];
  assign src2     = is_store ? rd_f[RW-1:0] : rm_f[RW-1:0];
  assign two_src  = !imm_bit || is_store;
  assign has_rn   = !((mode == 2'b10) ||
                      ((mode == 2'b00) && ((opcode == OP_MOV) || (opcode == OP_MVN))));

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = !z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = !c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = !n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = !v_f;
      4'b1000: cond_pass = c_f && !z_f;
      4'b1001: cond_pass = !c_f || z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = !z_f && (n_f == v_f);
      4'b1101: cond_pass = z_f || (n_f != v_f);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    dec_cmd   = 4'b0000;
    dec_mem_r = 1'b0;
    dec_mem_w = 1'b0;
    dec_wb    = 1'b0;
    dec_b     = 1'b0;
    dec_s     = 1'b0;
    case (mode)
      2'b00: begin
        dec_wb = 1'b1;
        dec_s  = s_bit;
        case (opcode)
          OP_MOV:  dec_cmd = 4'b0001;
          OP_MVN:  dec_cmd = 4'b1001;
          OP_ADD:  dec_cmd = 4'b0010;
          OP_ADC:  dec_cmd = 4'b0011;
          OP_SUB:  dec_cmd = 4'b0100;
          OP_SBC:  dec_cmd = 4'b0101;
          OP_AND:  dec_cmd = 4'b0110;
          OP_ORR:  dec_cmd = 4'b0111;
          OP_EOR:  dec_cmd = 4'b1000;
          OP_CMP: begin
            dec_cmd = 4'b0100;
            dec_wb  = 1'b0;
            dec_s   = 1'b1;
          end
          OP_TST: begin
            dec_cmd = 4'b0110;
            dec_wb  = 1'b0;
            dec_s   = 1'b1;
          end
          default: begin
            dec_wb = 1'b0;
            dec_s  = 1'b0;
          end
        endcase
      end
      2'b01: begin
        dec_cmd   = 4'b0010;
        dec_mem_r = s_bit;
        dec_mem_w = !s_bit;
        dec_wb    = s_bit;
      end
      2'b10:   dec_b = 1'b1;
      default: ;
    endcase
  end

  assign dec_ctrl = cond_pass ? {dec_cmd, dec_mem_r, dec_mem_w, dec_wb, dec_b, dec_s} : 9'd0;

  // Out-of-range indices read as zero; the bypass only applies to writes that would land.
  always_comb begin
    rd_rn = '0;
    rd_rm = '0;
    if (in_range(src1)) rd_rn = regs[src1];
    if (in_range(src2)) rd_rm = regs[src2];
`ifdef ID_WB_BYPASS_EN
    if (wb_en && in_range(wb_dest) && (wb_dest == src1)) rd_rn = wb_data;
    if (wb_en && in_range(wb_dest) && (wb_dest == src2)) rd_rm = wb_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en && in_range(wb_dest)) begin
      regs[wb_dest] <= wb_data;
    end
  end

  assign adv         = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv && !hazard && !flush;
  assign accept      = bus.in_valid && bus.in_ready;

  // Flush wins even over a stalled slot; bubbles leave the datapath fields untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      val_rn_q    <= '0;
      val_rm_q    <= '0;
      imm_q       <= 1'b0;
      shift_q     <= '0;
      simm_q      <= '0;
      dest_q      <= '0;
      pc_q        <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
    end else if (adv) begin
      out_valid_q <= accept;
      if (accept) begin
        ctrl_q   <= dec_ctrl;
        val_rn_q <= rd_rn;
        val_rm_q <= rd_rm;
        imm_q    <= imm_bit;
        shift_q  <= bus.instr[11:0];
        simm_q   <= bus.instr[23:0];
        dest_q   <= rd_f[RW-1:0];
        pc_q     <= bus.pc;
      end else begin
        ctrl_q <= '0;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign {bus.out_exe_cmd, bus.out_mem_r, bus.out_mem_w, bus.out_wb_en, bus.out_b, bus.out_s} = ctrl_q;
  assign bus.out_val_rn   = val_rn_q;
  assign bus.out_val_rm   = val_rm_q;
  assign bus.out_imm      = imm_q;
  assign bus.out_shift_op = shift_q;
  assign bus.out_simm24   = simm_q;
  assign bus.out_dest     = dest_q;
  assign bus.out_pc       = pc_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: decode-table vectors, directed handshake corner cases and a randomized run
// against a transaction-level model of the decode stage.
module tb_id_stage_pipe;
  localparam int DATA_W = 32;
  localparam int NREG   = 16;
  localparam int RW     = 4;
`ifdef ID_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        sr;
  logic              hazard, flush, wb_en;
  logic [RW-1:0]     wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic [RW-1:0]     src1, src2;
  logic              two_src, has_rn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage_pipe_if #(.DATA_W(DATA_W), .RW(RW)) bus ();

  id_stage_pipe #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sr(sr), .hazard(hazard), .flush(flush),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .src1(src1), .src2(src2), .two_src(two_src), .has_rn(has_rn)
  );

  typedef struct {
    logic              valid;
    logic [8:0]        ctrl;
    logic [DATA_W-1:0] val_rn, val_rm, pc;
    logic              imm;
    logic [11:0]       shift_op;
    logic [23:0]       simm24;
    logic [3:0]        dest;
  } exe_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [3:0]  sr;
    logic [8:0]  ctrl;
    logic        has_rn;
    logic        two_src;
    logic [3:0]  src2;
  } vec_t;

  // ALU command per data-processing opcode; 0 marks an opcode outside the subset.
  localparam logic [3:0] ALU_OF [16] = '{4'd6, 4'd8, 4'd4, 4'd0, 4'd2, 4'd3, 4'd5, 4'd0,
                                         4'd6, 4'd0, 4'd4, 4'd0, 4'd7, 4'd1, 4'd0, 4'd9};

  logic [DATA_W-1:0] mregs [NREG];
  exe_t              m;

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [1:0] md, input logic i,
                                     input logic [3:0] op, input logic s, input logic [3:0] rn,
                                     input logic [3:0] rd, input logic [11:0] op2);
    return {c, md, i, op, s, rn, rd, op2};
  endfunction

  // ARM pairs conditions: odd codes are the negation of the even code before them.
  function automatic logic condHolds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic [DATA_W-1:0] rdModel(input logic [3:0] idx);
    if (BYPASS && wb_en && (wb_dest == idx)) return wb_data;
    return mregs[idx];
  endfunction

  function automatic exe_t decodeModel(input logic [31:0] ins, input logic [3:0] f,
                                       input logic [DATA_W-1:0] rnv, input logic [DATA_W-1:0] rmv,
                                       input logic [DATA_W-1:0] p);
    exe_t e;
    logic [3:0] cmd, op;
    logic mr, mw, wb, b, s;
    op = ins[24:21];
    cmd = 4'd0; mr = 0; mw = 0; wb = 0; b = 0; s = 0;
    if (ins[27:26] == 2'd0 && ALU_OF[op] != 4'd0) begin
      cmd = ALU_OF[op];
      if (op == 4'd10 || op == 4'd8) s = 1'b1;
      else begin wb = 1'b1; s = ins[20]; end
    end else if (ins[27:26] == 2'd1) begin
      cmd = 4'd2; mr = ins[20]; mw = !ins[20]; wb = ins[20];
    end else if (ins[27:26] == 2'd2) begin
      b = 1'b1;
    end
    e.valid    = 1'b1;
    e.ctrl     = condHolds(ins[31:28], f) ? {cmd, mr, mw, wb, b, s} : 9'd0;
    e.val_rn   = rnv;
    e.val_rm   = rmv;
    e.imm      = ins[25];
    e.shift_op = ins[11:0];
    e.simm24   = ins[23:0];
    e.dest     = ins[15:12];
    e.pc       = p;
    return e;
  endfunction

  function automatic logic [8:0] dutCtrl();
    return {bus.out_exe_cmd, bus.out_mem_r, bus.out_mem_w, bus.out_wb_en, bus.out_b, bus.out_s};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [DATA_W-1:0] p,
                               input logic [3:0] f, input logic hz, input logic fl, input logic rdy);
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.pc        = p;
    sr            = f;
    hazard        = hz;
    flush         = fl;
    bus.out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkSlot(input string tag, input exe_t e);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'(e.valid));
    checkOutput({tag, "_ctrl"}, 32'(dutCtrl()), 32'(e.ctrl));
    if (e.valid) begin
      checkOutput({tag, "_val_rn"}, bus.out_val_rn, e.val_rn);
      checkOutput({tag, "_val_rm"}, bus.out_val_rm, e.val_rm);
      checkOutput({tag, "_fields"}, {bus.out_imm, bus.out_shift_op, bus.out_dest},
                  {15'd0, e.imm, e.shift_op, e.dest});
      checkOutput({tag, "_simm24"}, 32'(bus.out_simm24), 32'(e.simm24));
      checkOutput({tag, "_pc"}, bus.out_pc, e.pc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    logic [31:0] add123;
    logic [31:0] ins;
    logic [3:0]  rsrc2;
    logic        rstore, radv, rready;

    rst = 1'b0; wb_en = 1'b0; wb_dest = '0; wb_data = '0;
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_ctrl", 32'(dutCtrl()), 32'd0);
    checkOutput("reset_dest_pc", bus.out_pc | 32'(bus.out_dest), 32'd0);
    checkOutput("reset_val_rn", bus.out_val_rn, 32'd0);
    rst = 1'b1;

    wb_en = 1'b1; wb_dest = 4'd2; wb_data = 32'd5;
    tick();
    wb_dest = 4'd3; wb_data = 32'd7;
    tick();
    wb_en = 1'b0;

    // Basic ADD R1,R2,R3
    add123 = mk(4'hE, 2'd0, 1'b0, 4'd4, 1'b0, 4'd2, 4'd1, 12'h003);
    applyStimulus(1'b1, add123, 32'h100, 4'd0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("t1_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("t1_src1", 32'(src1), 32'd2);
    tick();
    checkOutput("t1_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t1_ctrl", 32'(dutCtrl()), {23'd0, 4'b0010, 5'b00100});
    checkOutput("t1_val_rn", bus.out_val_rn, 32'd5);
    checkOutput("t1_val_rm", bus.out_val_rm, 32'd7);
    checkOutput("t1_dest", 32'(bus.out_dest), 32'd1);

    // Hazard for two cycles then issue ADD R4,R3,R2
    applyStimulus(1'b1, mk(4'hE, 2'd0, 1'b0, 4'd4, 1'b0, 4'd3, 4'd4, 12'h002), 32'h104, 4'd0,
                  1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      #1;
      checkOutput("t2_in_ready_hazard", 32'(bus.in_ready), 32'd0);
      tick();
      checkOutput("t2_bubble", 32'(bus.out_valid), 32'd0);
    end
    hazard = 1'b0;
    #1;
    checkOutput("t2_in_ready_release", 32'(bus.in_ready), 32'd1);
    tick();
    checkOutput("t2_issue_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t2_issue_val_rn", bus.out_val_rn, 32'd7);
    checkOutput("t2_issue_dest", 32'(bus.out_dest), 32'd4);

    // Downstream stall, then flush
    applyStimulus(1'b1, mk(4'hE, 2'd0, 1'b0, 4'd2, 1'b0, 4'd2, 4'd6, 12'h003), 32'h108, 4'd0,
                  1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("t3_in_ready_stall", 32'(bus.in_ready), 32'd0);
      tick();
      checkOutput("t3_hold_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("t3_hold_pc_dest", {bus.out_pc[27:0], bus.out_dest}, {28'h104, 4'd4});
      checkOutput("t3_hold_ctrl", 32'(dutCtrl()), {23'd0, 4'b0010, 5'b00100});
    end
    flush = 1'b1;
    #1;
    checkOutput("t3_in_ready_flush", 32'(bus.in_ready), 32'd0);
    tick();
    checkOutput("t3_flush_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t3_flush_ctrl", 32'(dutCtrl()), 32'd0);
    flush = 1'b0; bus.out_ready = 1'b1;
    tick();
    checkOutput("t3_after_flush_ctrl", 32'(dutCtrl()), {23'd0, 4'b0100, 5'b00100});
    checkOutput("t3_after_flush_pc", bus.out_pc, 32'h108);

    // Decode table: {name, instr, sr, ctrl {cmd,mem_r,mem_w,wb,b,s}, has_rn, two_src, src2}
    vecs.push_back('{"add",   add123, 4'h0, {4'b0010, 5'b00100}, 1'b1, 1'b1, 4'd3});
    vecs.push_back('{"mov",   mk(4'hE, 2'd0, 1'b1, 4'd13, 1'b0, 4'd0, 4'd1, 12'h005), 4'h0, {4'b0001, 5'b00100}, 1'b0, 1'b0, 4'd5});
    vecs.push_back('{"mvns",  mk(4'hE, 2'd0, 1'b0, 4'd15, 1'b1, 4'd0, 4'd4, 12'h006), 4'h0, {4'b1001, 5'b00101}, 1'b0, 1'b1, 4'd6});
    vecs.push_back('{"adc",   mk(4'hE, 2'd0, 1'b1, 4'd5, 1'b0, 4'd1, 4'd2, 12'h0F3), 4'h0, {4'b0011, 5'b00100}, 1'b1, 1'b0, 4'd3});
    vecs.push_back('{"subs",  mk(4'hE, 2'd0, 1'b0, 4'd2, 1'b1, 4'd7, 4'd0, 12'h008), 4'h0, {4'b0100, 5'b00101}, 1'b1, 1'b1, 4'd8});
    vecs.push_back('{"sbc",   mk(4'hE, 2'd0, 1'b0, 4'd6, 1'b0, 4'd1, 4'd2, 12'h009), 4'h0, {4'b0101, 5'b00100}, 1'b1, 1'b1, 4'd9});
    vecs.push_back('{"and",   mk(4'hE, 2'd0, 1'b1, 4'd0, 1'b0, 4'd1, 4'd2, 12'h0A0), 4'h0, {4'b0110, 5'b00100}, 1'b1, 1'b0, 4'd0});
    vecs.push_back('{"orr",   mk(4'hE, 2'd0, 1'b0, 4'd12, 1'b0, 4'd1, 4'd2, 12'h00A), 4'h0, {4'b0111, 5'b00100}, 1'b1, 1'b1, 4'd10});
    vecs.push_back('{"eors",  mk(4'hE, 2'd0, 1'b0, 4'd1, 1'b1, 4'd1, 4'd2, 12'h00B), 4'h0, {4'b1000, 5'b00101}, 1'b1, 1'b1, 4'd11});
    vecs.push_back('{"cmp",   mk(4'hE, 2'd0, 1'b0, 4'd10, 1'b1, 4'd2, 4'd0, 12'h003), 4'h0, {4'b0100, 5'b00001}, 1'b1, 1'b1, 4'd3});
    vecs.push_back('{"tst",   mk(4'hE, 2'd0, 1'b1, 4'd8, 1'b0, 4'd2, 4'd0, 12'h0FF), 4'h0, {4'b0110, 5'b00001}, 1'b1, 1'b0, 4'd15});
    vecs.push_back('{"undef", mk(4'hE, 2'd0, 1'b0, 4'd3, 1'b1, 4'd2, 4'd1, 12'h004), 4'h0, 9'd0, 1'b1, 1'b1, 4'd4});
    vecs.push_back('{"ldr",   mk(4'hE, 2'd1, 1'b1, 4'd12, 1'b1, 4'd2, 4'd1, 12'h004), 4'h0, {4'b0010, 5'b10100}, 1'b1, 1'b0, 4'd4});
    vecs.push_back('{"str",   mk(4'hE, 2'd1, 1'b1, 4'd12, 1'b0, 4'd5, 4'd4, 12'h008), 4'h0, {4'b0010, 5'b01000}, 1'b1, 1'b1, 4'd4});
    vecs.push_back('{"b",     mk(4'hE, 2'd2, 1'b1, 4'd0, 1'b0, 4'd1, 4'd2, 12'h345), 4'h0, {4'b0000, 5'b00010}, 1'b0, 1'b0, 4'd5});
    vecs.push_back('{"beq_z0", mk(4'h0, 2'd2, 1'b1, 4'd7, 1'b1, 4'd9, 4'd8, 12'h765), 4'b0000, 9'd0, 1'b0, 1'b0, 4'd5});
    vecs.push_back('{"beq_z1", mk(4'h0, 2'd2, 1'b1, 4'd7, 1'b1, 4'd9, 4'd8, 12'h765), 4'b0100, {4'b0000, 5'b00010}, 1'b0, 1'b0, 4'd5});
    vecs.push_back('{"mode11", mk(4'hE, 2'd3, 1'b0, 4'd4, 1'b0, 4'd2, 4'd1, 12'h003), 4'h0, 9'd0, 1'b1, 1'b1, 4'd3});
    vecs.push_back('{"never", mk(4'hF, 2'd0, 1'b0, 4'd4, 1'b0, 4'd2, 4'd1, 12'h003), 4'hF, 9'd0, 1'b1, 1'b1, 4'd3});
    vecs.push_back('{"gt_pass", mk(4'hC, 2'd0, 1'b0, 4'd4, 1'b0, 4'd2, 4'd1, 12'h003), 4'b1001, {4'b0010, 5'b00100}, 1'b1, 1'b1, 4'd3});
    vecs.push_back('{"lt_fail", mk(4'hB, 2'd0, 1'b0, 4'd4, 1'b0, 4'd2, 4'd1, 12'h003), 4'b0000, 9'd0, 1'b1, 1'b1, 4'd3});
    vecs.push_back('{"hi_pass", mk(4'h8, 2'd0, 1'b0, 4'd4, 1'b0, 4'd2, 4'd1, 12'h003), 4'b0010, {4'b0010, 5'b00100}, 1'b1, 1'b1, 4'd3});
    vecs.push_back('{"ls_fail", mk(4'h9, 2'd0, 1'b0, 4'd4, 1'b0, 4'd2, 4'd1, 12'h003), 4'b0010, 9'd0, 1'b1, 1'b1, 4'd3});
    vecs.push_back('{"ne_pass", mk(4'h1, 2'd0, 1'b1, 4'd13, 1'b0, 4'd0, 4'd3, 12'h0FF), 4'b1011, {4'b0001, 5'b00100}, 1'b0, 1'b0, 4'd15});

    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].instr, 32'h200 + 32'(i), vecs[i].sr, 1'b0, 1'b0, 1'b1);
      #1;
      checkOutput({"tbl_", vecs[i].name, "_comb"}, {bus.in_ready, has_rn, two_src, src2},
                  {1'b1, vecs[i].has_rn, vecs[i].two_src, vecs[i].src2});
      tick();
      checkOutput({"tbl_", vecs[i].name, "_valid"}, 32'(bus.out_valid), 32'd1);
      checkOutput({"tbl_", vecs[i].name, "_ctrl"}, 32'(dutCtrl()), 32'(vecs[i].ctrl));
      checkOutput({"tbl_", vecs[i].name, "_simm24"}, 32'(bus.out_simm24), 32'(vecs[i].instr[23:0]));
      checkOutput({"tbl_", vecs[i].name, "_dest"}, 32'(bus.out_dest), 32'(vecs[i].instr[15:12]));
    end

    // Same-cycle write-back to a register being read
    applyStimulus(1'b1, add123, 32'h300, 4'd0, 1'b0, 1'b0, 1'b1);
    wb_en = 1'b1; wb_dest = 4'd2; wb_data = 32'hA5;
    tick();
    checkOutput("t6_val_rn_same_cycle", bus.out_val_rn, BYPASS ? 32'hA5 : 32'd5);
    checkOutput("t6_val_rm_same_cycle", bus.out_val_rm, 32'd7);
    wb_en = 1'b0;
    tick();
    checkOutput("t6_val_rn_next", bus.out_val_rn, 32'hA5);

    // Reset in the middle of a downstream stall
    bus.out_ready = 1'b0;
    tick();
    checkOutput("rs_stalled_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b0;
    tick();
    checkOutput("rs_cleared_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rs_cleared_ctrl_pc", 32'(dutCtrl()) | bus.out_pc, 32'd0);
    rst = 1'b1; bus.out_ready = 1'b1;
    #1;
    checkOutput("rs_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    checkOutput("rs_reissue_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("rs_reissue_val_rn", bus.out_val_rn, 32'd0);
    checkOutput("rs_reissue_ctrl", 32'(dutCtrl()), {23'd0, 4'b0010, 5'b00100});

    // Randomized run against the model, starting from a known reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m = '{default: '0};
    for (int r = 0; r < NREG; r++) mregs[r] = '0;

    for (int c = 0; c < 600; c++) begin
      ins = $urandom();
      if ($urandom_range(0, 9) < 6) ins[31:28] = 4'hE;
      applyStimulus($urandom_range(0, 9) < 8, ins, $urandom(), 4'($urandom()),
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8,
                    $urandom_range(0, 9) < 7);
      wb_en   = $urandom_range(0, 1) == 1;
      wb_dest = 4'($urandom());
      wb_data = $urandom();
      rst     = $urandom_range(0, 99) != 0;
      #1;
      rstore = (ins[27:26] == 2'd1) && !ins[20];
      rsrc2  = rstore ? ins[15:12] : ins[3:0];
      radv   = !m.valid || bus.out_ready;
      rready = radv && !hazard && !flush;
      checkOutput("rnd_in_ready", 32'(bus.in_ready), 32'(rready));
      checkOutput("rnd_src", {src1, src2}, {ins[19:16], rsrc2});
      checkOutput("rnd_two_src", 32'(two_src), 32'(!ins[25] || rstore));
      checkOutput("rnd_has_rn", 32'(has_rn),
                  32'(!(ins[27:26] == 2'd2 ||
                        (ins[27:26] == 2'd0 && (ins[24:21] == 4'd13 || ins[24:21] == 4'd15)))));
      if (!rst) begin
        m = '{default: '0};
        for (int r = 0; r < NREG; r++) mregs[r] = '0;
      end else begin
        if (flush) begin
          m.valid = 1'b0; m.ctrl = '0;
        end else if (radv) begin
          if (bus.in_valid && rready)
            m = decodeModel(ins, sr, rdModel(ins[19:16]), rdModel(rsrc2), bus.pc);
          else begin
            m.valid = 1'b0; m.ctrl = '0;
          end
        end
        if (wb_en) mregs[wb_dest] = wb_data;
      end
      tick();
      checkSlot("rnd", m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
